// File: rtl/itch_msg_parser.sv
// ITCH byte-stream parser: frames 18-byte big-endian messages, validates them and writes parsed_msg_t to the FIFO.
// Optional PARSER_CHECKSUM_EN adds a 19th XOR checksum byte covering bytes 0-17.
package parser_defs;
   typedef enum logic [1:0] {
      MSG_ADD    = 2'd0,
      MSG_UPDATE = 2'd1,
      MSG_DELETE = 2'd2
   } msg_type_t;

   typedef enum logic {
      ORDER_SIDE_BID = 1'b0,
      ORDER_SIDE_ASK = 1'b1
   } order_side_t;

   typedef struct packed {
      msg_type_t   msg_type;
      order_side_t side;
      logic [15:0] stock_id;
      logic [31:0] order_id;
      logic [31:0] price;
      logic [31:0] quantity;
   } parsed_msg_t;
endpackage

module itch_msg_parser
   import parser_defs::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   input  logic             s_sop,
   input  logic [7:0]       s_data,
   output logic             s_ready,
   input  logic             fifo_full,
   output logic             fifo_wr_en,
   output parsed_msg_t      fifo_wr_data,
   output logic [CNT_W-1:0] msg_count,
   output logic [CNT_W-1:0] err_count
);

`ifdef PARSER_CHECKSUM_EN
   localparam logic [4:0] LAST_IDX = 5'd18;
`else
   localparam logic [4:0] LAST_IDX = 5'd17;
`endif

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      EMIT
   } state_t;

   state_t      state;
   logic [4:0]  idx;
   logic [127:0] body;
   logic        xfer;
   logic        type_ok;
   logic        side_ok;
   logic        msg_ok;
   msg_type_t   dec_type;
   order_side_t dec_side;
   parsed_msg_t next_msg;
`ifdef PARSER_CHECKSUM_EN
   logic [7:0]  xor_acc;
`endif

   assign s_ready    = (state != EMIT);
   assign fifo_wr_en = (state == EMIT) && !fifo_full;
   assign xfer       = s_valid && s_ready;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Bytes 0-15 are shifted in MSB first, so by the last byte the fields sit at fixed offsets of body.
   always_comb begin
      type_ok  = 1'b1;
      side_ok  = 1'b1;
      dec_type = MSG_ADD;
      dec_side = ORDER_SIDE_BID;
      case (body[127:120])
         8'h41:   dec_type = MSG_ADD;
         8'h55:   dec_type = MSG_UPDATE;
         8'h44:   dec_type = MSG_DELETE;
         default: type_ok  = 1'b0;
      endcase
      case (body[119:112])
         8'h42:   dec_side = ORDER_SIDE_BID;
         8'h53:   dec_side = ORDER_SIDE_ASK;
         default: side_ok  = 1'b0;
      endcase
`ifdef PARSER_CHECKSUM_EN
      msg_ok = type_ok && side_ok && (s_data == xor_acc);
`else
      msg_ok = type_ok && side_ok;
`endif
      next_msg.msg_type = dec_type;
      next_msg.side     = dec_side;
      next_msg.stock_id = body[111:96];
      next_msg.order_id = body[95:64];
      next_msg.price    = body[63:32];
      next_msg.quantity = body[31:0];
   end

   // A start-of-message byte always restarts framing; the message is judged only on its final byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= '0;
         body         <= '0;
         fifo_wr_data <= '0;
         msg_count    <= '0;
         err_count    <= '0;
`ifdef PARSER_CHECKSUM_EN
         xor_acc      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (xfer && s_sop) begin
                  body  <= {body[119:0], s_data};
                  idx   <= 5'd1;
                  state <= COLLECT;
`ifdef PARSER_CHECKSUM_EN
                  xor_acc <= s_data;
`endif
               end
            end
            COLLECT: begin
               if (xfer) begin
                  if (s_sop) begin
                     err_count <= sat_inc(err_count);
                     body      <= {body[119:0], s_data};
                     idx       <= 5'd1;
`ifdef PARSER_CHECKSUM_EN
                     xor_acc   <= s_data;
`endif
                  end else begin
                     if (idx < 5'd16) begin
                        body <= {body[119:0], s_data};
                     end
`ifdef PARSER_CHECKSUM_EN
                     xor_acc <= xor_acc ^ s_data;
`endif
                     if (idx == LAST_IDX) begin
                        idx <= '0;
                        if (msg_ok) begin
                           fifo_wr_data <= next_msg;
                           state        <= EMIT;
                        end else begin
                           err_count <= sat_inc(err_count);
                           state     <= IDLE;
                        end
                     end else begin
                        idx <= idx + 5'd1;
                     end
                  end
               end
            end
            EMIT: begin
               if (!fifo_full) begin
                  msg_count <= sat_inc(msg_count);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_itch_msg_parser.sv
// Directed self-checking bench for itch_msg_parser, built with CNT_W=4 so counter saturation is quick to reach.
module tb_itch_msg_parser;
   import parser_defs::*;

   localparam int CNT_W = 4;
`ifdef PARSER_CHECKSUM_EN
   localparam int MSG_LEN = 19;
`else
   localparam int MSG_LEN = 18;
`endif

   logic             clk;
   logic             reset;
   logic             s_valid;
   logic             s_sop;
   logic [7:0]       s_data;
   logic             s_ready;
   logic             fifo_full;
   logic             fifo_wr_en;
   parsed_msg_t      fifo_wr_data;
   logic [CNT_W-1:0] msg_count;
   logic [CNT_W-1:0] err_count;

   int          assertCount;
   int          failCount;
   int          wrCount;
   int          wrBefore;
   parsed_msg_t lastData;
   parsed_msg_t expMsg;
   logic [7:0]  msgBytes[19];

   itch_msg_parser #(.CNT_W(CNT_W)) dut (
      .clk(clk),
      .reset(reset),
      .s_valid(s_valid),
      .s_sop(s_sop),
      .s_data(s_data),
      .s_ready(s_ready),
      .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
      .msg_count(msg_count),
      .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // EMIT spans a full cycle, so sampling on the falling edge sees each write exactly once.
   always @(negedge clk) begin
      if (fifo_wr_en) begin
         wrCount  = wrCount + 1;
         lastData = fifo_wr_data;
      end
   end

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      assertCount = assertCount + 1;
      if (actual !== expected) begin
         failCount = failCount + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic sop, input logic [7:0] d);
      int guard;
      guard   = 0;
      s_valid = 1'b1;
      s_sop   = sop;
      s_data  = d;
      while (!s_ready && guard < 100) begin
         tick();
         guard++;
      end
      if (!s_ready) begin
         checkOutput("ready_timeout", 128'(s_ready), 128'(1));
         s_valid = 1'b0;
         s_sop   = 1'b0;
         return;
      end
      tick();
      s_valid = 1'b0;
      s_sop   = 1'b0;
   endtask

   task automatic buildMsg(input logic [7:0] t, input logic [7:0] s, input logic [15:0] stock,
                           input logic [31:0] oid, input logic [31:0] price, input logic [31:0] qty,
                           input logic badXor);
      logic [7:0] x;
      msgBytes[0]  = t;
      msgBytes[1]  = s;
      msgBytes[2]  = stock[15:8];
      msgBytes[3]  = stock[7:0];
      for (int i = 0; i < 4; i++) begin
         msgBytes[4 + i]  = oid[31 - 8*i -: 8];
         msgBytes[8 + i]  = price[31 - 8*i -: 8];
         msgBytes[12 + i] = qty[31 - 8*i -: 8];
      end
      msgBytes[16] = 8'hA5;
      msgBytes[17] = 8'h3C;
      x = 8'h00;
      for (int i = 0; i < 18; i++) x = x ^ msgBytes[i];
      msgBytes[18] = badXor ? ~x : x;
   endtask

   function automatic parsed_msg_t makeExpected(input logic [7:0] t, input logic [7:0] s, input logic [15:0] stock,
                                                input logic [31:0] oid, input logic [31:0] price, input logic [31:0] qty);
      parsed_msg_t m;
      m.msg_type = (t == 8'h41) ? MSG_ADD : (t == 8'h55) ? MSG_UPDATE : MSG_DELETE;
      m.side     = (s == 8'h42) ? ORDER_SIDE_BID : ORDER_SIDE_ASK;
      m.stock_id = stock;
      m.order_id = oid;
      m.price    = price;
      m.quantity = qty;
      return m;
   endfunction

   task automatic applyStimulus(input int first, input int last);
      for (int i = first; i <= last; i++) sendByte(i == 0, msgBytes[i]);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      #1;
      checkOutput("rst_wr_en", 128'(fifo_wr_en), 128'(0));
      checkOutput("rst_wr_data", 128'(fifo_wr_data), 128'(0));
      checkOutput("rst_msg_count", 128'(msg_count), 128'(0));
      checkOutput("rst_err_count", 128'(err_count), 128'(0));
      #3;
      reset = 1'b0;
      #1;
      checkOutput("rst_ready", 128'(s_ready), 128'(1));
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      wrCount     = 0;
      reset       = 1'b1;
      s_valid     = 1'b0;
      s_sop       = 1'b0;
      s_data      = 8'h00;
      fifo_full   = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset state
      checkOutput("reset_ready", 128'(s_ready), 128'(1));
      checkOutput("reset_wr_en", 128'(fifo_wr_en), 128'(0));
      checkOutput("reset_wr_data", 128'(fifo_wr_data), 128'(0));
      checkOutput("reset_msg_count", 128'(msg_count), 128'(0));
      checkOutput("reset_err_count", 128'(err_count), 128'(0));

      // Add bid: write strobe the cycle after the last byte
      buildMsg(8'h41, 8'h42, 16'h0001, 32'h5, 32'h64, 32'hA, 1'b0);
      expMsg = makeExpected(8'h41, 8'h42, 16'h0001, 32'h5, 32'h64, 32'hA);
      applyStimulus(0, MSG_LEN - 1);
      checkOutput("add_wr_en", 128'(fifo_wr_en), 128'(1));
      checkOutput("add_ready_emit", 128'(s_ready), 128'(0));
      checkOutput("add_wr_data", 128'(fifo_wr_data), 128'(expMsg));
      tick();
      checkOutput("add_msg_count", 128'(msg_count), 128'(1));
      checkOutput("add_wr_count", 128'(wrCount), 128'(1));
      checkOutput("add_ready_after", 128'(s_ready), 128'(1));

      // Back-pressure on a delete/ask message
      buildMsg(8'h44, 8'h53, 16'hBEEF, 32'hDEADBEEF, 32'h00012345, 32'h7FFFFFFF, 1'b0);
      expMsg = makeExpected(8'h44, 8'h53, 16'hBEEF, 32'hDEADBEEF, 32'h00012345, 32'h7FFFFFFF);
      applyStimulus(0, MSG_LEN - 2);
      fifo_full = 1'b1;
      applyStimulus(MSG_LEN - 1, MSG_LEN - 1);
      wrBefore = wrCount;
      for (int c = 0; c < 10; c++) begin
         checkOutput("bp_ready_hold", 128'(s_ready), 128'(0));
         checkOutput("bp_wr_en_hold", 128'(fifo_wr_en), 128'(0));
         tick();
      end
      checkOutput("bp_no_write", 128'(wrCount), 128'(wrBefore));
      checkOutput("bp_data_stable", 128'(fifo_wr_data), 128'(expMsg));
      fifo_full = 1'b0;
      #1;
      checkOutput("bp_wr_en_release", 128'(fifo_wr_en), 128'(1));
      tick();
      checkOutput("bp_one_write", 128'(wrCount), 128'(wrBefore + 1));
      checkOutput("bp_last_data", 128'(lastData), 128'(expMsg));
      checkOutput("bp_ready_after", 128'(s_ready), 128'(1));
      checkOutput("bp_msg_count", 128'(msg_count), 128'(2));

      // Invalid type, then a valid update/bid
      buildMsg(8'h58, 8'h42, 16'h0002, 32'h6, 32'h10, 32'h1, 1'b0);
      wrBefore = wrCount;
      applyStimulus(0, MSG_LEN - 1);
      checkOutput("bad_type_wr_en", 128'(fifo_wr_en), 128'(0));
      checkOutput("bad_type_err", 128'(err_count), 128'(1));
      tick();
      checkOutput("bad_type_no_write", 128'(wrCount), 128'(wrBefore));
      buildMsg(8'h55, 8'h42, 16'h1234, 32'h00000777, 32'h000003E8, 32'h00000020, 1'b0);
      expMsg = makeExpected(8'h55, 8'h42, 16'h1234, 32'h00000777, 32'h000003E8, 32'h00000020);
      applyStimulus(0, MSG_LEN - 1);
      tick();
      checkOutput("upd_write", 128'(wrCount), 128'(wrBefore + 1));
      checkOutput("upd_data", 128'(lastData), 128'(expMsg));
      checkOutput("upd_msg_count", 128'(msg_count), 128'(3));

      // Stray byte without sop in IDLE is ignored
      sendByte(1'b0, 8'h41);
      checkOutput("stray_err", 128'(err_count), 128'(1));
      checkOutput("stray_ready", 128'(s_ready), 128'(1));

      // Early sop at byte 9 aborts the first message and starts a new one
      buildMsg(8'h41, 8'h53, 16'h0F0F, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0);
      applyStimulus(0, 8);
      buildMsg(8'h41, 8'h42, 16'h00AA, 32'h00000099, 32'h00000555, 32'h00000003, 1'b0);
      expMsg = makeExpected(8'h41, 8'h42, 16'h00AA, 32'h00000099, 32'h00000555, 32'h00000003);
      wrBefore = wrCount;
      applyStimulus(0, MSG_LEN - 1);
      checkOutput("early_sop_err", 128'(err_count), 128'(2));
      tick();
      checkOutput("early_sop_write", 128'(wrCount), 128'(wrBefore + 1));
      checkOutput("early_sop_data", 128'(lastData), 128'(expMsg));

      // Reset while stalled in EMIT
      buildMsg(8'h44, 8'h42, 16'h0003, 32'h7, 32'h8, 32'h9, 1'b0);
      fifo_full = 1'b1;
      applyStimulus(0, MSG_LEN - 1);
      wrBefore = wrCount;
      pulseReset();
      fifo_full = 1'b0;
      repeat (3) tick();
      checkOutput("rst_emit_no_write", 128'(wrCount), 128'(wrBefore));

      // Reset at byte 7, remaining bytes arrive without sop and are dropped
      buildMsg(8'h41, 8'h42, 16'h0004, 32'hA, 32'hB, 32'hC, 1'b0);
      applyStimulus(0, 6);
      pulseReset();
      applyStimulus(7, MSG_LEN - 1);
      repeat (2) tick();
      checkOutput("rst_mid_no_write", 128'(wrCount), 128'(wrBefore));
      checkOutput("rst_mid_err", 128'(err_count), 128'(0));
      checkOutput("rst_mid_msg", 128'(msg_count), 128'(0));

`ifdef PARSER_CHECKSUM_EN
      // Correct and corrupted checksum bytes
      buildMsg(8'h55, 8'h53, 16'h4321, 32'h0000ABCD, 32'h00000100, 32'h00000050, 1'b0);
      expMsg = makeExpected(8'h55, 8'h53, 16'h4321, 32'h0000ABCD, 32'h00000100, 32'h00000050);
      applyStimulus(0, MSG_LEN - 1);
      tick();
      checkOutput("csum_good_write", 128'(wrCount), 128'(wrBefore + 1));
      checkOutput("csum_good_data", 128'(lastData), 128'(expMsg));
      checkOutput("csum_good_msg", 128'(msg_count), 128'(1));
      buildMsg(8'h55, 8'h53, 16'h4321, 32'h0000ABCD, 32'h00000100, 32'h00000050, 1'b1);
      applyStimulus(0, MSG_LEN - 1);
      tick();
      checkOutput("csum_bad_no_write", 128'(wrCount), 128'(wrBefore + 1));
      checkOutput("csum_bad_err", 128'(err_count), 128'(1));
`endif

      // Error counter saturation via repeated sop aborts
      for (int i = 0; i < 20; i++) sendByte(1'b1, 8'h41);
      checkOutput("sat_err", 128'(err_count), 128'(15));
      sendByte(1'b1, 8'h41);
      checkOutput("sat_err_hold", 128'(err_count), 128'(15));

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
